programmer_mc: RTL

PROGRAMMER_MC -- requirements
Module: programmer_mc

---
 rtl/programmer_mc.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/programmer_mc.sv
// programmer_mc: byte-stream ROM programmer.
// A serial byte stream (qualified by data_tick) carries framed write requests.
// A frame is a run of SYNC_LEN or more "s" bytes, a target id, a 4-byte
// little-endian base byte address, a payload of 32-bit little-endian words,
// an "e" terminator and a checksum byte. "q" escapes the next byte. Complete
// payload words are written to the selected target while the frame is still
// arriving. The selected target is held in reset for the duration of the frame.
//
// Ports:
//   clk        - clock, rising edge
//   rst_in     - asynchronous active-low reset
//   data_tick  - one-cycle strobe qualifying data
//   data       - received byte
//   rst_out    - per-target hold-in-reset (NUM_TARGETS bits)
//   wen        - per-target one-cycle write strobe (NUM_TARGETS bits)
//   waddr      - shared byte write address (ADDR_W+2 bits, low 2 bits zero)
//   wdata      - shared 32-bit write data
//   busy       - high while a frame is being received
//   done       - one-cycle pulse on a frame accepted with a good checksum
//   err        - one-cycle pulse on an aborted frame or a checksum failure
//   err_code   - 1 bad target, 2 framing, 3 checksum; holds until the next err
module programmer_mc #(
  parameter int SYNC_LEN    = 5,
  parameter int NUM_TARGETS = 2,
  parameter int ADDR_W      = 30
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   data_tick,
  input  logic [7:0]             data,
  output logic [NUM_TARGETS-1:0] rst_out,
  output logic [NUM_TARGETS-1:0] wen,
  output logic [ADDR_W+1:0]      waddr,
  output logic [31:0]            wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam int TGT_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam logic [NUM_TARGETS-1:0] TGT_ONE = NUM_TARGETS'(1);
  localparam logic [7:0] CH_S = 8'h73;
  localparam logic [7:0] CH_E = 8'h65;
  localparam logic [7:0] CH_Q = 8'h71;

  typedef enum logic [1:0] {SYNC, HDR, DATA, CSUM} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             sync_cnt_q, sync_cnt_d;
  logic                   esc_q, esc_d;
  logic [TGT_W-1:0]       target_q, target_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [23:0]            word_q, word_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [7:0]             csum_q, csum_d;
  logic [NUM_TARGETS-1:0] wen_q, wen_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [1:0]             err_code_q, err_code_d;

  // The incoming byte joined with the three previously received bytes forms
  // a little-endian word; it serves both the header and the payload.
  logic [31:0] shifted;
  logic [63:0] hdr_ext;
  logic [7:0]  csum_add;
  logic        unused_bits;

  assign shifted     = {data, word_q};
  assign hdr_ext     = {32'd0, shifted};
  assign csum_add    = csum_q + data;
  assign unused_bits = ^hdr_ext;

  assign busy     = (state_q != SYNC);
  assign rst_out  = busy ? (TGT_ONE << target_q) : '0;
  assign wen      = wen_q;
  assign waddr    = {addr_q, 2'b00};
  assign wdata    = wdata_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

  // Next-state logic. Control characters are recognised only when no escape
  // is pending; an escaped byte is always treated as literal data.
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    esc_d      = esc_q;
    target_d   = target_q;
    addr_d     = addr_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    wen_d      = '0;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    // The word address advances in the cycle after each write strobe.
    if (|wen_q) addr_d = addr_q + ADDR_W'(1);

    if (data_tick) begin
      if (state_q == SYNC) begin
        if (data == CH_S) begin
          if (sync_cnt_q < 4'(SYNC_LEN)) sync_cnt_d = sync_cnt_q + 4'd1;
        end else begin
          sync_cnt_d = 4'd0;
          if (sync_cnt_q == 4'(SYNC_LEN)) begin
            if (data >= 8'(NUM_TARGETS)) begin
              err_d      = 1'b1;
              err_code_d = 2'd1;
            end else begin
              target_d   = data[TGT_W-1:0];
              state_d    = HDR;
              csum_d     = data;
              byte_cnt_d = 2'd0;
              esc_d      = 1'b0;
            end
          end
        end
      end else if (!esc_q && data == CH_Q) begin
        esc_d = 1'b1;
      end else if (!esc_q && data == CH_S) begin
        // An aborting "s" already counts towards the next sync run.
        state_d    = SYNC;
        sync_cnt_d = 4'd1;
        esc_d      = 1'b0;
        err_d      = 1'b1;
        err_code_d = 2'd2;
      end else if (!esc_q && data == CH_E) begin
        if (state_q == DATA && byte_cnt_q == 2'd0) begin
          state_d = CSUM;
        end else begin
          state_d    = SYNC;
          sync_cnt_d = 4'd0;
          err_d      = 1'b1;
          err_code_d = 2'd2;
        end
      end else begin
        esc_d  = 1'b0;
        csum_d = csum_add;
        case (state_q)
          HDR: begin
            word_d     = shifted[31:8];
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              addr_d  = hdr_ext[ADDR_W+1:2];
              state_d = DATA;
            end
          end
          DATA: begin
            word_d     = shifted[31:8];
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              wen_d   = TGT_ONE << target_q;
              wdata_d = shifted;
            end
          end
          default: begin
            state_d    = SYNC;
            sync_cnt_d = 4'd0;
            if (csum_add == 8'd0) begin
              done_d = 1'b1;
            end else begin
              err_d      = 1'b1;
              err_code_d = 2'd3;
            end
          end
        endcase
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= SYNC;
      sync_cnt_q <= '0;
      esc_q      <= 1'b0;
      target_q   <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      wen_q      <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      esc_q      <= esc_d;
      target_q   <= target_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

endmodule
